clk_en_seq: RTL and testbench
=============================

// Module: clk_en_seq
// PURPOSE
//  Single-clock replacement for the ripple-clock divider.
//  - Generates a one-cycle clock-enable strobe every DIV fast cycles.
//  - Sequences the divided domain's reset and global write enable: reset is
//    held until the DCM reports lock, then for RST_CYC strobe periods.
//  - Sits between the DCM output and the gwe/rst pins of every Nbit_reg in
//    the slow logic, so slow logic runs on the fast clock with no extra BUFG.
// PARAMETERS
//  DIV      8   fast cycles per strobe; legal range 2..2^DIV_W
//  DIV_W    3   phase counter width
//  RST_CYC  16  strobe periods sys_rst is held after lock; >=1
//  RST_W    5   reset-period counter width; 2^RST_W > RST_CYC
// PORTS
//  clk_16MHz  in   1      fast clock; all state changes on its rising edge
//  reset_n    in   1      asynchronous, active-low reset
//  locked     in   1      DCM lock; asynchronous, synchronised internally
//  soft_rst   in   1      synchronous active-high request to re-sequence
//  clk_en     out  1      one-cycle strobe, period DIV
//  phase      out  DIV_W  current phase counter value
//  sys_rst    out  1      active-high reset for slow-domain registers
//  gwe        out  1      global write enable (clk_en gated by RUN)
//  ready      out  1      high while in RUN
// BEHAVIOUR
//  Reset (reset_n=0, async):
//  - phase=0, clk_en=0, sync flops=0, rcnt=0, state=WAIT_LOCK.
//  - sys_rst=1, gwe=0, ready=0.
//  Phase counter:
//  - Free-runs whenever reset_n=1: 0..DIV-1, then wraps to 0.
//  - Not affected by the FSM, locked or soft_rst.
//  - clk_en is registered: clk_en <= (phase==DIV-1).
//  - The first strobe is high during the cycle after edge DIV following
//    reset release. Strobes then repeat every DIV cycles, exactly 1 cycle wide.
//  Lock synchroniser:
//  - 2-flop synchroniser, locked -> locked_s; 2-edge latency.
//  FSM (WAIT_LOCK, FLUSH, RUN):
//  - Priority soft_rst > !locked_s > advance.
//  - WAIT_LOCK: if locked_s & clk_en & !soft_rst -> FLUSH, with rcnt=0.
//  - FLUSH: on each sampled clk_en, rcnt++.
//    - When clk_en & rcnt==RST_CYC-1 -> RUN.
//    - soft_rst or !locked_s -> WAIT_LOCK, rcnt cleared.
//  - RUN: soft_rst or !locked_s -> WAIT_LOCK.
//  Outputs (no combinational path from locked or soft_rst to any output):
//  - sys_rst = (state!=RUN), from registered state.
//  - ready = (state==RUN).
//  - gwe = clk_en & (state==RUN).
//  Boundary cases:
//  - Lock loss in RUN: sys_rst=1 and gwe=0 from the cycle after locked_s
//    falls. If that cycle has a clk_en strobe, gwe stays low.
//  - soft_rst coincident with a clk_en strobe in RUN: gwe is still 1 that
//    cycle (state is still RUN); RUN is left on that edge.
//  - Lock regained mid-period: FLUSH starts only on a strobe. Slow-domain
//    reset release is always strobe-aligned.
//  - reset_n asserted mid-operation: immediate return to reset values.
// TESTING
//  1. DIV=8, reset_n released before edge 1 -> clk_en high only during the
//     cycles after edges 8, 16, 24...; phase wraps 7->0.
//  2. locked=1 from start, RST_CYC=16 -> FLUSH entered at edge 9; RUN entered
//     and sys_rst=0 after edge 137; first gwe pulse after edge 144.
//  3. locked dropped for 1 cycle while in RUN -> sys_rst=1 three edges later.
//     FSM re-enters FLUSH on the next strobe and RUN 16 strobes after that.
//  4. soft_rst pulsed mid-FLUSH -> WAIT_LOCK and rcnt=0. The full 16-strobe
//     reset period is repeated and sys_rst is never released early.
//  5. reset_n pulsed low mid-RUN -> all outputs at reset values
//     asynchronously; phase restarts at 0.
//  6. DIV=2, RST_CYC=1 -> clk_en alternates every cycle. RUN is reached one
//     strobe after FLUSH entry, and gwe==clk_en thereafter.

Source files
------------

// File: rtl/clk_en_seq.sv
// clk_en_seq: clock-enable strobe generator and sequencer for the slow domain's reset and global write enable.
// Latency: clk_en rises one cycle after phase==DIV-1; locked reaches the FSM two edges after it changes.
// Backpressure: none; the block runs freely and its outputs are valid every cycle.
module clk_en_seq #(
   parameter int DIV     = 8,
   parameter int DIV_W   = 3,
   parameter int RST_CYC = 16,
   parameter int RST_W   = 5
) (
   input  logic             clk_16MHz,
   input  logic             reset_n,
   input  logic             locked,
   input  logic             soft_rst,
   output logic             clk_en,
   output logic [DIV_W-1:0] phase,
   output logic             sys_rst,
   output logic             gwe,
   output logic             ready
);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      FLUSH     = 2'd1,
      RUN       = 2'd2
   } state_t;

   localparam logic [DIV_W-1:0] PH_LAST = DIV_W'(DIV - 1);
   localparam logic [RST_W-1:0] RC_LAST = RST_W'(RST_CYC - 1);

   logic [DIV_W-1:0] phase_q, phase_d;
   logic             clk_en_q, clk_en_d;
   logic             lock_meta_q, locked_s_q;
   state_t           state_q, state_d;
   logic [RST_W-1:0] rcnt_q, rcnt_d;

   // Phase counter wraps at DIV-1; the strobe is registered so it has no decode glitches.
   always_comb begin
      phase_d  = (phase_q == PH_LAST) ? '0 : phase_q + DIV_W'(1);
      clk_en_d = (phase_q == PH_LAST);
   end

   // Phase counter and strobe run freely; the FSM has no effect on them.
   always_ff @(posedge clk_16MHz or negedge reset_n) begin
      if (!reset_n) begin
         phase_q  <= '0;
         clk_en_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         clk_en_q <= clk_en_d;
      end
   end

   // Two-flop synchroniser for the asynchronous DCM lock signal.
   always_ff @(posedge clk_16MHz or negedge reset_n) begin
      if (!reset_n) begin
         lock_meta_q <= 1'b0;
         locked_s_q  <= 1'b0;
      end else begin
         lock_meta_q <= locked;
         locked_s_q  <= lock_meta_q;
      end
   end

   // Sequencer next state. soft_rst has priority over lock loss, which has priority over advancing.
   // Every forward step waits for a strobe, so the slow domain leaves reset on a strobe boundary.
   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      case (state_q)
         WAIT_LOCK: begin
            rcnt_d = '0;
            if (!soft_rst && locked_s_q && clk_en_q) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (soft_rst || !locked_s_q) begin
               state_d = WAIT_LOCK;
               rcnt_d  = '0;
            end else if (clk_en_q) begin
               rcnt_d = rcnt_q + RST_W'(1);
               if (rcnt_q == RC_LAST) begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (soft_rst || !locked_s_q) begin
               state_d = WAIT_LOCK;
            end
         end
         default: begin
            state_d = WAIT_LOCK;
            rcnt_d  = '0;
         end
      endcase
   end

   // Sequencer state and reset-period counter.
   always_ff @(posedge clk_16MHz or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= WAIT_LOCK;
         rcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         rcnt_q  <= rcnt_d;
      end
   end

   // All outputs come from registered state only; locked and soft_rst cannot reach them combinationally.
   assign clk_en  = clk_en_q;
   assign phase   = phase_q;
   assign ready   = (state_q == RUN);
   assign sys_rst = (state_q != RUN);
   assign gwe     = clk_en_q & (state_q == RUN);

endmodule

// File: tb/tb_clk_en_seq.sv
// tb_clk_en_seq: checks the strobe generator and sequencer for DIV=8/RST_CYC=16 and DIV=2/RST_CYC=1.
// Latency: the bench compares DUT outputs 1 time unit after each rising edge.
// Backpressure: none; the bench drives inputs at its own pace.
module tb_clk_en_seq;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       locked;
   logic       soft_rst;
   logic       en_a, rst_a, gwe_a, rdy_a;
   logic [2:0] ph_a;
   logic       en_b, rst_b, gwe_b, rdy_b;
   logic [0:0] ph_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   clk_en_seq #(.DIV(8), .DIV_W(3), .RST_CYC(16), .RST_W(5)) dut_a (
      .clk_16MHz(clk), .reset_n(reset_n), .locked(locked), .soft_rst(soft_rst),
      .clk_en(en_a), .phase(ph_a), .sys_rst(rst_a), .gwe(gwe_a), .ready(rdy_a)
   );

   clk_en_seq #(.DIV(2), .DIV_W(1), .RST_CYC(1), .RST_W(1)) dut_b (
      .clk_16MHz(clk), .reset_n(reset_n), .locked(locked), .soft_rst(soft_rst),
      .clk_en(en_b), .phase(ph_b), .sys_rst(rst_b), .gwe(gwe_b), .ready(rdy_b)
   );

   // Reference model. n counts edges since reset release. good is -1 while waiting for lock,
   // then counts the strobes seen since the reset period began; good==rc means the slow domain runs.
   // s1 and s2 hold the locked samples taken at the last two edges.
   typedef struct {
      int n;
      int good;
      bit s1;
      bit s2;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t mdl_rst();
      mdl_t m;
      m.n    = 0;
      m.good = -1;
      m.s1   = 1'b0;
      m.s2   = 1'b0;
      return m;
   endfunction

   function automatic bit mdl_en(mdl_t m, int div);
      return (m.n >= div) && (m.n % div == 0);
   endfunction

   function automatic mdl_t mdl_adv(mdl_t m, int div, int rc, bit lk, bit sr);
      bit en;
      en = mdl_en(m, div);
      if (sr || !m.s2) begin
         m.good = -1;
      end else if (en) begin
         if (m.good < 0)       m.good = 0;
         else if (m.good < rc) m.good = m.good + 1;
      end
      m.s2 = m.s1;
      m.s1 = lk;
      m.n  = m.n + 1;
      return m;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_all();
      chk("a_phase",  32'(ph_a),  32'(ma.n % 8));
      chk("a_clk_en", 32'(en_a),  32'(mdl_en(ma, 8)));
      chk("a_ready",  32'(rdy_a), 32'(ma.good == 16));
      chk("a_sysrst", 32'(rst_a), 32'(ma.good != 16));
      chk("a_gwe",    32'(gwe_a), 32'(mdl_en(ma, 8) && ma.good == 16));
      chk("b_phase",  32'(ph_b),  32'(mb.n % 2));
      chk("b_clk_en", 32'(en_b),  32'(mdl_en(mb, 2)));
      chk("b_ready",  32'(rdy_b), 32'(mb.good == 1));
      chk("b_sysrst", 32'(rst_b), 32'(mb.good != 1));
      chk("b_gwe",    32'(gwe_b), 32'(mdl_en(mb, 2) && mb.good == 1));
   endtask

   task automatic step();
      @(posedge clk);
      ma = mdl_adv(ma, 8, 16, locked, soft_rst);
      mb = mdl_adv(mb, 2, 1, locked, soft_rst);
      #1;
      chk_all();
   endtask

   // Asynchronous reset in the middle of a cycle; outputs must return to reset values without a clock edge.
   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      chk("rst_phase",  32'(ph_a),  32'd0);
      chk("rst_clk_en", 32'(en_a),  32'd0);
      chk("rst_sysrst", 32'(rst_a), 32'd1);
      chk("rst_gwe",    32'(gwe_a), 32'd0);
      chk("rst_ready",  32'(rdy_a), 32'd0);
      chk("rst_b_rst",  32'(rst_b), 32'd1);
      ma = mdl_rst();
      mb = mdl_rst();
      chk_all();
      reset_n = 1'b1;
   endtask

   // Count the strobes seen while ready is low, up to the cycle in which ready rises.
   task automatic count_to_ready(output int cnt);
      int g;
      cnt = 0;
      g   = 0;
      while (!rdy_a && g < 400) begin
         if (en_a) cnt++;
         step();
         g++;
      end
      chk("ready_timeout", 32'(rdy_a), 32'd1);
   endtask

   typedef struct {
      int         edge_n;
      bit         lk;
      bit         sr;
      logic [2:0] ph;
      bit         en;
      bit         rst;
      bit         rdy;
      bit         gw;
   } vec_t;

   vec_t vt[10];

   initial begin
      int cnt;
      int g;
      vt[0] = '{1,   1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[1] = '{7,   1'b1, 1'b0, 3'd7, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[2] = '{8,   1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[3] = '{9,   1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[4] = '{16,  1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[5] = '{136, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[6] = '{137, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0};
      vt[7] = '{143, 1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0};
      vt[8] = '{144, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1};
      vt[9] = '{145, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0};

      locked   = 1'b1;
      soft_rst = 1'b0;
      do_reset();

      // Strobe timing and lock-to-RUN sequence with the lock held from the start.
      for (int i = 0; i < 10; i++) begin
         g = 0;
         while (ma.n < vt[i].edge_n && g < 1000) begin
            locked   = vt[i].lk;
            soft_rst = vt[i].sr;
            step();
            g++;
         end
         chk("vec_phase",  32'(ph_a),  32'(vt[i].ph));
         chk("vec_clk_en", 32'(en_a),  32'(vt[i].en));
         chk("vec_sysrst", 32'(rst_a), 32'(vt[i].rst));
         chk("vec_ready",  32'(rdy_a), 32'(vt[i].rdy));
         chk("vec_gwe",    32'(gwe_a), 32'(vt[i].gw));
      end

      // One-cycle lock loss in RUN, timed so that sys_rst rises in a strobe cycle.
      while (ma.n < 157) step();
      locked = 1'b0;
      step();
      locked = 1'b1;
      step();
      chk("lockloss_hold", 32'(rst_a), 32'd0);
      step();
      chk("lockloss_rst",  32'(rst_a), 32'd1);
      chk("lockloss_en",   32'(en_a),  32'd1);
      chk("lockloss_gwe",  32'(gwe_a), 32'd0);
      count_to_ready(cnt);
      chk("relock_strobes", 32'(cnt), 32'd17);

      // soft_rst in the middle of FLUSH restarts the whole reset period.
      do_reset();
      while (ma.n < 60) step();
      chk("flush_before_soft", 32'(rst_a), 32'd1);
      soft_rst = 1'b1;
      step();
      soft_rst = 1'b0;
      chk("soft_rst_hold", 32'(rst_a), 32'd1);
      count_to_ready(cnt);
      chk("soft_strobes", 32'(cnt), 32'd17);

      // soft_rst coinciding with a strobe in RUN: gwe stays high that cycle; RUN is left on that edge.
      while (!en_a) step();
      soft_rst = 1'b1;
      chk("soft_gwe_same", 32'(gwe_a), 32'd1);
      step();
      soft_rst = 1'b0;
      chk("soft_left_run", 32'(rdy_a), 32'd0);

      // Asynchronous reset in the middle of RUN; the phase counter restarts from 0.
      count_to_ready(cnt);
      step();
      step();
      do_reset();
      step();
      chk("post_rst_phase", 32'(ph_a), 32'd1);

      // DIV=2, RST_CYC=1: FLUSH at edge 3, RUN at edge 5, then gwe follows clk_en.
      while (mb.n < 4) step();
      chk("b_not_run_4", 32'(rdy_b), 32'd0);
      step();
      chk("b_run_5", 32'(rdy_b), 32'd1);
      for (int i = 0; i < 8; i++) begin
         step();
         chk("b_gwe_eq_en", 32'(gwe_b), 32'(en_b));
         chk("b_alt_en",    32'(en_b),  32'(mb.n % 2 == 0));
      end

      // Random lock loss, soft resets and resets, checked against the model every cycle.
      for (int i = 0; i < 6000; i++) begin
         int r;
         r = int'($urandom_range(0, 9999));
         if (r < 30)        locked = 1'b0;
         else if (r < 530)  locked = 1'b1;
         soft_rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 2999) == 0) begin
            soft_rst = 1'b0;
            do_reset();
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
